// File: rtl/sha256_round_unit_pkg.sv
// Shared SHA-256 helpers for the round unit: working-state struct, round count, IV and logical functions.
package sha256_round_unit_pkg;

  localparam int SHA256_ROUNDS = 64;

  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational 64x32 ROM of the SHA-256 round constants K[0..63].
module sha256_k_rom (
  input  logic [5:0]  addr,
  output logic [31:0] k
);

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  assign k = K_TABLE[addr];

endmodule

// File: rtl/sha256_round_unit.sv
// SHA-256 compression stage: optional start delay, 64 rounds fed by the W[t] stream on in0,
// then the chaining value plus final state is registered on out0..out7.
module sha256_round_unit
  import sha256_round_unit_pkg::*;
#(
  parameter int DELAY_W = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DATA_W-1:0]  in1,
  input  logic [DATA_W-1:0]  in2,
  input  logic [DATA_W-1:0]  in3,
  input  logic [DATA_W-1:0]  in4,
  input  logic [DATA_W-1:0]  in5,
  input  logic [DATA_W-1:0]  in6,
  input  logic [DATA_W-1:0]  in7,
  input  logic [DATA_W-1:0]  in8,
  (* versat_latency = 65 *) output logic [DATA_W-1:0] out0,
  (* versat_latency = 65 *) output logic [DATA_W-1:0] out1,
  (* versat_latency = 65 *) output logic [DATA_W-1:0] out2,
  (* versat_latency = 65 *) output logic [DATA_W-1:0] out3,
  (* versat_latency = 65 *) output logic [DATA_W-1:0] out4,
  (* versat_latency = 65 *) output logic [DATA_W-1:0] out5,
  (* versat_latency = 65 *) output logic [DATA_W-1:0] out6,
  (* versat_latency = 65 *) output logic [DATA_W-1:0] out7,
  input  logic [DELAY_W-1:0] delay0
);

  logic [DELAY_W-1:0] delay_q;
  logic [6:0]         round_q;
  logic               busy_q;
  work_t              st_q;
  work_t              st_nx;
  logic [31:0]        hv_q [8];
  logic [31:0]        k_t;
  logic [31:0]        t1;
  logic [31:0]        t2;
  logic               round_phase;
  logic               last_round;

  // Interface-uniformity input with no function in this unit.
  logic unused_running;
  assign unused_running = running;

  sha256_k_rom u_k_rom (
    .addr (round_q[5:0]),
    .k    (k_t)
  );

  assign round_phase = busy_q && (delay_q == '0);
  assign last_round  = round_phase && (round_q == 7'(SHA256_ROUNDS - 1));
  assign done        = ~(busy_q | run);

  always_comb begin
    t1 = st_q.h + big_sigma1(st_q.e) + ch(st_q.e, st_q.f, st_q.g) + k_t + in0;
    t2 = big_sigma0(st_q.a) + maj(st_q.a, st_q.b, st_q.c);
    st_nx   = st_q;
    st_nx.a = t1 + t2;
    st_nx.b = st_q.a;
    st_nx.c = st_q.b;
    st_nx.d = st_q.c;
    st_nx.e = st_q.d + t1;
    st_nx.f = st_q.e;
    st_nx.g = st_q.f;
    st_nx.h = st_q.g;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_q <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      st_q    <= '0;
      for (int i = 0; i < 8; i++) hv_q[i] <= '0;
      {out0, out1, out2, out3, out4, out5, out6, out7} <= '0;
    end else if (run) begin
      // Restart discards any block in flight; outputs keep the last completed digest.
      delay_q <= delay0;
      round_q <= '0;
      busy_q  <= 1'b1;
      hv_q    <= '{in1, in2, in3, in4, in5, in6, in7, in8};
      st_q    <= '{a: in1, b: in2, c: in3, d: in4, e: in5, f: in6, g: in7, h: in8};
    end else if (busy_q) begin
      if (!round_phase) begin
        delay_q <= delay_q - 1'b1;
      end else begin
        st_q <= st_nx;
        if (last_round) begin
          busy_q  <= 1'b0;
          round_q <= '0;
          out0    <= hv_q[0] + st_nx.a;
          out1    <= hv_q[1] + st_nx.b;
          out2    <= hv_q[2] + st_nx.c;
          out3    <= hv_q[3] + st_nx.d;
          out4    <= hv_q[4] + st_nx.e;
          out5    <= hv_q[5] + st_nx.f;
          out6    <= hv_q[6] + st_nx.g;
          out7    <= hv_q[7] + st_nx.h;
        end else begin
          round_q <= round_q + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_round_unit.sv
// Bench for sha256_round_unit: NIST vectors, start delay, mid-block reset/restart and idle hold.
module tb_sha256_round_unit;

  typedef logic [31:0] blk_t   [16];
  typedef logic [31:0] sched_t [64];
  typedef logic [31:0] hv_t    [8];

  logic        clk = 1'b0;
  logic        rst;
  logic        running;
  logic        run;
  logic        done;
  logic [31:0] in0, in1, in2, in3, in4, in5, in6, in7, in8;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [31:0] delay0;

  int checks = 0;
  int errors = 0;
  logic [255:0] sb_q [$];

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_BLK_DIGEST =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  hv_t    iv;
  sched_t w_abc;
  sched_t w_b1;
  sched_t w_b2;

  sha256_round_unit #(.DELAY_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .done(done),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in5(in5), .in6(in6), .in7(in7), .in8(in8),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7),
    .delay0(delay0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sched_t expand(input blk_t b);
    sched_t w;
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w[i] = b[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    return w;
  endfunction

  function automatic logic [255:0] digest();
    return {out0, out1, out2, out3, out4, out5, out6, out7};
  endfunction

  // Drives the run cycle and returns at the falling edge after it with run low.
  task automatic start_run(input hv_t hv, input int dly);
    @(negedge clk);
    run = 1'b1;
    {in1, in2, in3, in4, in5, in6, in7, in8} = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
    delay0 = dly;
    in0 = 32'h0;
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_drop_on_run: got %b want 0", done);
    end
    @(negedge clk);
    run = 1'b0;
  endtask

  // Presents W[from..to-1], preceded by dly filler cycles when starting at W[0]; counts done-low cycles.
  task automatic feed(input sched_t w, input int dly, input int from, input int to, output int low);
    low = 0;
    if (from == 0) begin
      for (int d = 0; d < dly; d++) begin
        if (done === 1'b0) low++;
        in0 = 32'hdeadbeef ^ d;
        @(negedge clk);
      end
    end
    for (int t = from; t < to; t++) begin
      if (done === 1'b0) low++;
      in0 = w[t];
      @(negedge clk);
    end
  endtask

  task automatic finish_block(input string name, input bit compare, inout int low, output logic [255:0] got);
    int n = 0;
    logic [255:0] exp_d;
    while (done !== 1'b1 && n < 20) begin
      low++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b after %0d extra cycles, want 1", name, done, n);
    end
    got = digest();
    if (compare) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s_scoreboard_empty: got %h want a queued digest", name, got);
      end else begin
        exp_d = sb_q.pop_front();
        if (got !== exp_d) begin
          errors++;
          $display("FAIL %s_digest: got %h want %h", name, got, exp_d);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; running = 1'b0; run = 1'b0; delay0 = 0;
    {in0, in1, in2, in3, in4, in5, in6, in7, in8} = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (digest() !== 256'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", digest());
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL reset_done: got %b want 1", done);
    end
    rst = 1'b0;
  endtask

  task automatic test_abc_single();
    int low;
    int tot;
    logic [255:0] got;
    sb_q.push_back(ABC_DIGEST);
    start_run(iv, 0);
    feed(w_abc, 0, 0, 64, low);
    tot = low + 1;
    finish_block("abc", 1'b1, tot, got);
    checks++;
    if (tot != 65) begin
      errors++;
      $display("FAIL abc_done_low_cycles: got %0d want 65", tot);
    end
  endtask

  task automatic test_delay();
    int low;
    int tot;
    logic [255:0] got;
    sb_q.push_back(ABC_DIGEST);
    start_run(iv, 5);
    checks++;
    if (digest() !== ABC_DIGEST) begin
      errors++;
      $display("FAIL delay_hold_prev: got %h want %h", digest(), ABC_DIGEST);
    end
    feed(w_abc, 5, 0, 64, low);
    tot = low + 1;
    finish_block("delay5", 1'b1, tot, got);
    checks++;
    if (tot != 70) begin
      errors++;
      $display("FAIL delay5_done_low_cycles: got %0d want 70", tot);
    end
  endtask

  task automatic test_two_block();
    int low;
    logic [255:0] got;
    hv_t h1;
    start_run(iv, 0);
    feed(w_b1, 0, 0, 64, low);
    finish_block("blk1", 1'b0, low, got);
    for (int i = 0; i < 8; i++) h1[i] = got[255 - 32*i -: 32];
    sb_q.push_back(TWO_BLK_DIGEST);
    start_run(h1, 0);
    feed(w_b2, 0, 0, 64, low);
    finish_block("blk2", 1'b1, low, got);
  endtask

  task automatic test_rst_mid();
    int low;
    logic [255:0] got;
    start_run(iv, 0);
    feed(w_abc, 0, 0, 30, low);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (digest() !== 256'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h want 0", digest());
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_done: got %b want 1", done);
    end
    rst = 1'b0;
    sb_q.push_back(ABC_DIGEST);
    start_run(iv, 0);
    feed(w_abc, 0, 0, 64, low);
    finish_block("after_rst", 1'b1, low, got);
  endtask

  task automatic test_restart();
    int low;
    logic [255:0] got;
    start_run(iv, 0);
    feed(w_b1, 0, 0, 40, low);
    checks++;
    if (digest() !== ABC_DIGEST) begin
      errors++;
      $display("FAIL restart_hold_before: got %h want %h", digest(), ABC_DIGEST);
    end
    sb_q.push_back(ABC_DIGEST);
    start_run(iv, 0);
    feed(w_abc, 0, 0, 63, low);
    checks++;
    if (digest() !== ABC_DIGEST || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_hold_during: got %h done=%b want %h done=0", digest(), done, ABC_DIGEST);
    end
    feed(w_abc, 0, 63, 64, low);
    finish_block("restart", 1'b1, low, got);
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      checks++;
      if (digest() !== ABC_DIGEST || done !== 1'b1) begin
        errors++;
        $display("FAIL idle_hold_%0d: got %h done=%b want %h done=1", i, digest(), done, ABC_DIGEST);
      end
    end
  endtask

  initial begin
    blk_t b_abc, b1, b2;
    iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    b_abc = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000018};
    b1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
           32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
           32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
           32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    b2 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000001c0};
    w_abc = expand(b_abc);
    w_b1  = expand(b1);
    w_b2  = expand(b2);

    test_reset();
    test_abc_single();
    test_idle_hold();
    test_delay();
    test_two_block();
    test_rst_mid();
    test_restart();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
